// File: rtl/alu_seq_ctrl.sv
// Purpose : fetch/execute control unit for the 4-bit ALU; owns R0..R3, C/Z flags and the PC.
// Latency : 3 cycles per instruction with zero-wait memory (FETCH, EXEC, WB) plus one DONE cycle.
// Backpr. : FETCH holds imem_req/imem_addr until imem_ack; wait states are unbounded.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, prog_len          run request (IDLE only) and instruction count, latched on start
//   busy, done               run in progress / one-cycle end-of-run pulse
//   imem_req/addr/rdata/ack  instruction fetch handshake, addr = pc
//   alu_sel/a/b/cin, alu_f/cout  ALU operands out (EXEC only), result in
//   c_flag, z_flag           flags from the last write-back
//   dbg_we/addr/wdata/rdata  register-file debug access (writes honoured in IDLE)
module alu_seq_ctrl #(
    parameter int PC_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [PC_W-1:0] prog_len,
    output logic            busy,
    output logic            done,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [7:0]      imem_rdata,
    input  logic            imem_ack,
    output logic [2:0]      alu_sel,
    output logic [3:0]      alu_a,
    output logic [3:0]      alu_b,
    output logic            alu_cin,
    input  logic [3:0]      alu_f,
    input  logic            alu_cout,
    output logic            c_flag,
    output logic            z_flag,
    input  logic            dbg_we,
    input  logic [1:0]      dbg_addr,
    input  logic [3:0]      dbg_wdata,
    output logic [3:0]      dbg_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WB,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] len_q;
    logic [7:0]      instr_q;
    logic [3:0]      rf_q [4];
    logic [3:0]      res_q;
    logic            cy_q;
    logic            c_q;
    logic            z_q;
    logic            busy_q;
    logic            done_q;
    logic            req_q;

    // Next sequential PC; wraps modulo 2^PC_W and doubles as the end-of-run compare value.
    assign pc_d = pc_q + PC_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            instr_q <= '0;
            res_q   <= '0;
            cy_q    <= 1'b0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            req_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            // done is a single-cycle pulse: only the transition into DONE raises it.
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (dbg_we) begin
                        rf_q[dbg_addr] <= dbg_wdata;
                    end
                    if (start) begin
                        len_q  <= prog_len;
                        pc_q   <= '0;
                        busy_q <= 1'b1;
                        if (prog_len == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_FETCH;
                            req_q   <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        instr_q <= imem_rdata;
                        req_q   <= 1'b0;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    res_q   <= alu_f;
                    cy_q    <= alu_cout;
                    state_q <= S_WB;
                end
                S_WB: begin
                    rf_q[instr_q[3:2]] <= res_q;
                    c_q                <= cy_q;
                    z_q                <= (res_q == 4'd0);
                    pc_q               <= pc_d;
                    if (pc_d == len_q) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_FETCH;
                        req_q   <= 1'b1;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    // ALU operands are a pure decode of registered state, so they are glitch-free
    // and read the register file as it stands during EXEC.
    logic exec_w;
    assign exec_w  = (state_q == S_EXEC);
    assign alu_sel = exec_w ? instr_q[7:5]       : 3'd0;
    assign alu_cin = exec_w ? instr_q[4]         : 1'b0;
    assign alu_a   = exec_w ? rf_q[instr_q[3:2]] : 4'd0;
    assign alu_b   = exec_w ? rf_q[instr_q[1:0]] : 4'd0;

    assign busy      = busy_q;
    assign done      = done_q;
    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign c_flag    = c_q;
    assign z_flag    = z_q;
    assign dbg_rdata = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_seq_ctrl.sv
module tb_alu_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] prog_len;
    logic       busy, done, imem_req;
    logic [3:0] imem_addr;
    logic [7:0] imem_rdata;
    logic       imem_ack;
    logic [2:0] alu_sel;
    logic [3:0] alu_a, alu_b, alu_f;
    logic       alu_cin, alu_cout;
    logic       c_flag, z_flag;
    logic       dbg_we;
    logic [1:0] dbg_addr;
    logic [3:0] dbg_wdata, dbg_rdata;

    alu_seq_ctrl #(.PC_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .prog_len(prog_len),
        .busy(busy), .done(done), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_f(alu_f), .alu_cout(alu_cout), .c_flag(c_flag), .z_flag(z_flag),
        .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Stand-in for the team ALU: {cout, f}. Logic ops return cout=0.
    function automatic logic [4:0] alu_fn(input logic [2:0] s, input logic [3:0] a,
                                          input logic [3:0] b, input logic ci);
        case (s)
            3'd0:    return {1'b0, a};
            3'd1:    return {1'b0, a} + {1'b0, b} + {4'd0, ci};
            3'd2:    return {1'b0, a} + {1'b0, ~b} + {4'd0, ci};
            3'd3:    return {1'b0, a & b};
            3'd4:    return {1'b0, a | b};
            3'd5:    return {1'b0, a ^ b};
            3'd6:    return {1'b0, b};
            default: return {1'b0, ~a};
        endcase
    endfunction

    logic [4:0] alu_r;
    always_comb alu_r = alu_fn(alu_sel, alu_a, alu_b, alu_cin);
    assign alu_f    = alu_r[3:0];
    assign alu_cout = alu_r[4];

    // ---------------- program memory with configurable wait states ----------------
    logic [7:0] prog [16];
    int ack_wait = 0;
    int wcnt     = 0;

    always @(posedge clk) begin
        #1;
        if (imem_req) begin
            if (wcnt == ack_wait) begin
                imem_ack   = 1'b1;
                imem_rdata = prog[imem_addr];
                wcnt       = 0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 8'($urandom);
                wcnt++;
            end
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = 8'($urandom);
            wcnt       = 0;
        end
    end

    // ---------------- transaction-level model ----------------
    typedef struct packed {
        logic        busy, done, req;
        logic [3:0]  addr;
        logic [2:0]  sel;
        logic [3:0]  a, b;
        logic        cin;
        logic [15:0] regs;
        logic        c, z;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] mr [4];
    logic [3:0] mpc;
    logic       mc, mz;
    logic       chk_en = 1'b0;

    function automatic exp_t rec(input logic bz, input logic dn, input logic rq, input logic [3:0] ad,
                                 input logic [2:0] s, input logic [3:0] a, input logic [3:0] b,
                                 input logic ci);
        exp_t e;
        e.busy = bz; e.done = dn; e.req = rq; e.addr = ad;
        e.sel = s; e.a = a; e.b = b; e.cin = ci;
        e.regs = {mr[3], mr[2], mr[1], mr[0]};
        e.c = mc; e.z = mz;
        return e;
    endfunction

    // Expected per-cycle trace of a whole run: each instruction is (waits+1) fetch
    // cycles, one execute cycle, one write-back cycle; registers change after write-back.
    task automatic build_run(input int len, input int waits);
        logic [7:0] ins;
        logic [4:0] r;
        mpc = 4'd0;
        for (int i = 0; i < len; i++) begin
            ins = prog[i];
            repeat (waits + 1) exp_q.push_back(rec(1, 0, 1, 4'(i), 0, 0, 0, 0));
            exp_q.push_back(rec(1, 0, 0, 4'(i), ins[7:5], mr[ins[3:2]], mr[ins[1:0]], ins[4]));
            exp_q.push_back(rec(1, 0, 0, 4'(i), 0, 0, 0, 0));
            r = alu_fn(ins[7:5], mr[ins[3:2]], mr[ins[1:0]], ins[4]);
            mr[ins[3:2]] = r[3:0];
            mc  = r[4];
            mz  = (r[3:0] == 4'd0);
            mpc = 4'(i + 1);
        end
        exp_q.push_back(rec(1, 1, 0, mpc, 0, 0, 0, 0));
    endtask

    // One compare process: every negedge, outputs against the next expected record
    // (or the idle state the model is resting in).
    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else                  e = rec(0, 0, 0, mpc, 0, 0, 0, 0);
            chk("cyc_busy", busy, e.busy);
            chk("cyc_done", done, e.done);
            chk("cyc_imem_req", imem_req, e.req);
            chk("cyc_imem_addr", imem_addr, e.addr);
            chk("cyc_alu_sel", alu_sel, e.sel);
            chk("cyc_alu_a", alu_a, e.a);
            chk("cyc_alu_b", alu_b, e.b);
            chk("cyc_alu_cin", alu_cin, e.cin);
            chk("cyc_c_flag", c_flag, e.c);
            chk("cyc_z_flag", z_flag, e.z);
            chk("cyc_dbg_rdata", dbg_rdata, e.regs[int'(dbg_addr)*4 +: 4]);
        end
    end

    // ---------------- stimulus helpers (all driven at posedge+1) ----------------
    task automatic dbg_wr(input logic [1:0] a, input logic [3:0] d);
        dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
        @(posedge clk); #1;
        dbg_we = 1'b0;
        mr[a] = d;
    endtask

    task automatic lit_reg(input string nm, input logic [1:0] a, input logic [3:0] v);
        dbg_addr = a;
        #1;
        chk(nm, dbg_rdata, v);
    endtask

    logic [2:0] ex_sel;
    logic [3:0] ex_a, ex_b;
    logic       ex_cin;

    // Returns the number of cycles from the accepted-start edge to the done cycle.
    task automatic run_prog(input logic [3:0] len, input int waits, input bit noise, output int lat);
        ack_wait = waits;
        start = 1'b1; prog_len = len;
        @(posedge clk); #1;
        start = 1'b0; prog_len = 4'($urandom);
        build_run(int'(len), waits);
        lat = 0;
        while (lat < 200) begin
            lat++;
            if (lat == 2) begin
                ex_sel = alu_sel; ex_a = alu_a; ex_b = alu_b; ex_cin = alu_cin;
            end
            if (done) break;
            dbg_addr = 2'($urandom);
            if (noise) begin
                start = 1'b1; prog_len = 4'($urandom);
                dbg_we = 1'b1; dbg_wdata = 4'($urandom);
            end
            @(posedge clk); #1;
        end
        start = 1'b0; dbg_we = 1'b0;
        if (lat >= 200) begin
            chk("run_done_timeout", 0, 1);
            exp_q.delete();
        end
    endtask

    int lat, lat0, latw;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) prog[i] = 8'd0;
        imem_ack = 1'b0; imem_rdata = 8'd0;
        start = 1'b0; prog_len = 4'd0; dbg_we = 1'b0; dbg_addr = 2'd0; dbg_wdata = 4'd0;

        // Reset with random inputs for two cycles.
        rst = 1'b1;
        repeat (2) begin
            start = 1'($urandom); prog_len = 4'($urandom);
            dbg_we = 1'($urandom); dbg_addr = 2'($urandom); dbg_wdata = 4'($urandom);
            @(posedge clk); #1;
        end
        rst = 1'b0; start = 1'b0; dbg_we = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_alu_sel", alu_sel, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_cin", alu_cin, 0);
        chk("rst_c_flag", c_flag, 0);
        chk("rst_z_flag", z_flag, 0);
        for (int i = 0; i < 4; i++) lit_reg("rst_dbg_rdata", 2'(i), 4'd0);
        for (int i = 0; i < 4; i++) mr[i] = 4'd0;
        mpc = 4'd0; mc = 1'b0; mz = 1'b0;
        chk_en = 1'b1;

        // ADD R0 = R0 + R1 : 5 + 3.
        dbg_wr(2'd0, 4'd5);
        dbg_wr(2'd1, 4'd3);
        prog[0] = 8'b001_0_00_01;
        run_prog(4'd1, 0, 0, lat);
        chk("add_latency", lat, 4);
        chk("add_exec_sel", ex_sel, 3'b001);
        chk("add_exec_a", ex_a, 4'd5);
        chk("add_exec_b", ex_b, 4'd3);
        chk("add_exec_cin", ex_cin, 0);
        @(posedge clk); #1;
        chk("add_busy_after", busy, 0);
        lit_reg("add_r0", 2'd0, 4'd8);
        chk("add_c", c_flag, 0);
        chk("add_z", z_flag, 0);

        // Carry/zero: F + 1 = 0 carry 1, then NOT R1.
        dbg_wr(2'd0, 4'hF);
        dbg_wr(2'd1, 4'd1);
        run_prog(4'd1, 0, 0, lat);
        @(posedge clk); #1;
        lit_reg("carry_r0", 2'd0, 4'd0);
        chk("carry_c", c_flag, 1);
        chk("carry_z", z_flag, 1);
        prog[0] = 8'b111_0_01_01;
        run_prog(4'd1, 0, 0, lat);
        @(posedge clk); #1;
        lit_reg("not_r1", 2'd1, 4'hE);
        chk("not_c", c_flag, 0);
        chk("not_z", z_flag, 0);

        // Two instructions: zero-wait, then 3 wait states per fetch.
        prog[0] = 8'b001_0_00_01;
        prog[1] = 8'b010_1_10_11;
        dbg_wr(2'd0, 4'd2); dbg_wr(2'd1, 4'd7); dbg_wr(2'd2, 4'd9); dbg_wr(2'd3, 4'd4);
        run_prog(4'd2, 0, 0, lat0);
        @(posedge clk); #1;
        chk("len2_latency", lat0, 7);
        dbg_wr(2'd0, 4'd2); dbg_wr(2'd1, 4'd7); dbg_wr(2'd2, 4'd9); dbg_wr(2'd3, 4'd4);
        run_prog(4'd2, 3, 0, latw);
        @(posedge clk); #1;
        chk("wait_latency", latw, 13);
        chk("wait_extra_cycles", latw - lat0, 6);
        lit_reg("wait_r0", 2'd0, 4'd9);
        lit_reg("wait_r2", 2'd2, 4'd5);
        chk("wait_c", c_flag, 1);
        chk("wait_z", z_flag, 0);

        // prog_len = 0: done in the cycle right after start.
        run_prog(4'd0, 0, 0, lat);
        @(posedge clk); #1;
        chk("len0_latency", lat, 1);

        // start and dbg_we hammered mid-run must not disturb anything.
        prog[0] = 8'b001_0_00_01;
        prog[1] = 8'b111_0_01_01;
        dbg_wr(2'd0, 4'd1); dbg_wr(2'd1, 4'd2);
        run_prog(4'd2, 1, 1, lat);
        @(posedge clk); #1;
        chk("noise_latency", lat, 9);
        lit_reg("noise_r0", 2'd0, 4'd3);
        lit_reg("noise_r1", 2'd1, 4'hD);
        chk("noise_busy_after", busy, 0);

        // Reset while in EXEC.
        chk_en = 1'b0;
        prog[0] = 8'b001_1_10_11;
        ack_wait = 0;
        start = 1'b1; prog_len = 4'd3;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("midrst_exec_sel", alu_sel, 3'b001);
        chk("midrst_exec_cin", alu_cin, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_imem_req", imem_req, 0);
        chk("midrst_imem_addr", imem_addr, 0);
        chk("midrst_c", c_flag, 0);
        chk("midrst_z", z_flag, 0);
        for (int i = 0; i < 4; i++) lit_reg("midrst_reg", 2'(i), 4'd0);
        for (int i = 0; i < 4; i++) mr[i] = 4'd0;
        mpc = 4'd0; mc = 1'b0; mz = 1'b0;
        exp_q.delete();
        chk_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Multi-cycle fetch/execute sequencer that drives the team's 4-bit combinational ALU (3-bit sel, a, b, cin → f, cout).
- Fetches 8-bit instructions over a req/ack instruction-memory port and maps each onto one ALU operation.
- Holds a 4×4-bit register file, carry and zero flags, and a program counter.
- Sits between program memory and the ALU as the control unit of the 4-bit processor.

Parameters:
- PC_W, 4, width of program counter, imem_addr and prog_len.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  run request; sampled only in IDLE.
- prog_len  in  PC_W  number of instructions to run; latched on an accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a run.
- imem_req  out  1  fetch request.
- imem_addr  out  PC_W  fetch address (= pc).
- imem_rdata  in  8  instruction data; valid when imem_ack=1.
- imem_ack  in  1  fetch complete.
- alu_sel  out  3  to ALU sel.
- alu_a  out  4  to ALU a.
- alu_b  out  4  to ALU b.
- alu_cin  out  1  to ALU cin.
- alu_f  in  4  ALU result.
- alu_cout  in  1  ALU carry out.
- c_flag  out  1  carry flag.
- z_flag  out  1  zero flag.
- dbg_we  in  1  register-file write; honoured in IDLE only.
- dbg_addr  in  2  debug register index (read and write).
- dbg_wdata  in  4  debug write data.
- dbg_rdata  out  4  combinational read of R[dbg_addr].

Behaviour:
- Reset (synchronous, active-high, wins over all other inputs):
  - state=IDLE, pc=0, R0..R3=0, c_flag=0, z_flag=0, instr=0.
  - busy=0, done=0, imem_req=0, imem_addr=0.
  - alu_sel/alu_a/alu_b/alu_cin=0.
- Instruction format:
  - [7:5] op → alu_sel.
  - [4] cin literal → alu_cin.
  - [3:2] rd → alu_a = R[rd]; result destination.
  - [1:0] rs → alu_b = R[rs].
- ALU outputs: alu_* are driven from the latched instr and the current register file in EXEC only; all zero otherwise.
- IDLE:
  - dbg_we writes R[dbg_addr]=dbg_wdata.
  - On start=1: latch prog_len, pc=0.
  - Latched prog_len=0 → DONE; else → FETCH.
- FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until ack.
  - imem_ack=1 at an edge → latch imem_rdata into instr, → EXEC.
  - Otherwise stay in FETCH; wait states are unbounded.
- EXEC:
  - ALU driven; register res=alu_f and cy=alu_cout.
  - → WB.
- WB:
  - R[rd]=res, c_flag=cy, z_flag=(res==0).
  - pc=pc+1, wrapping modulo 2^PC_W.
  - If pc+1 equals latched prog_len (PC_W-bit compare) → DONE; else → FETCH.
- DONE: done=1 for exactly this cycle, → IDLE. busy is high in FETCH, EXEC, WB and DONE.
- start while busy: ignored, with no effect on the current run.
- dbg_we outside IDLE: ignored.
- dbg_rdata: always valid, combinational.
- Flags: updated for every op including logic ops. For logic ops cy=alu_cout (ALU returns 0).
- Timing:
  - Zero-wait memory gives 3 cycles per instruction.
  - done asserts in the 4th cycle after the accepted-start edge for prog_len=1.
  - Each ack wait cycle adds 1 cycle.
- rd=rs is legal (e.g. R0=R0+R0).
- imem_ack outside FETCH: ignored.

Test Plan:
- Reset: assert rst 2 cycles with random inputs → all outputs 0, busy=0, dbg_rdata=0 for all 4 indices.
- ADD run:
  - Stimulus: dbg-write R0=5, R1=3; instr 8'b001_0_00_01; prog_len=1; zero-wait ack.
  - Required: R0=8, c_flag=0, z_flag=0.
  - Required: alu_sel=001, a=5, b=3, cin=0 in EXEC.
  - Required: done in 4th cycle after start, then busy=0.
- Carry/zero:
  - Stimulus: R0=4'hF, R1=1; same ADD instr.
  - Required: R0=0, c_flag=1, z_flag=1.
  - Then a second run, 8'b111_0_01_01 (NOT R1) → R1=4'hE, c_flag=0, z_flag=0.
- Wait states:
  - Stimulus: prog_len=2; ack delayed 3 cycles per fetch.
  - Required: imem_req held high with imem_addr stable (0 then 1); no register change during the wait.
  - Required: done exactly 6 cycles later than the zero-wait case.
- Boundaries:
  - prog_len=0 → done pulse in the cycle after start, no imem_req.
  - start pulsed mid-run → ignored.
  - dbg_we mid-run → R unchanged.
- Reset mid-operation: rst asserted in EXEC → next cycle IDLE, registers and flags 0, no done pulse, imem_req=0.
